// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types, funct3 encodings and outcome decode helpers for
//               the branch controller.
// Revision    : 1.0
// ============================================================================
package branch_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;
    localparam bht_cnt_t BHT_RESET = 2'b01;

    // 010/011 are the only encodings that are not conditional branches
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[2] | ~f3[1];
    endfunction

    function automatic logic f3_taken(input logic [2:0] f3,
                                      input logic       br_eq,
                                      input logic       br_lt);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:            t = br_eq;
            F3_BNE:            t = ~br_eq;
            F3_BLT, F3_BLTU:   t = br_lt;
            F3_BGE, F3_BGEU:   t = ~br_lt;
            default:           t = 1'b0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_ctrl_bht.sv
`default_nettype none
// ============================================================================
// Module      : bht
// Description : Branch history table of 2-bit saturating counters with one
//               combinational lookup port and one synchronous update port.
// Revision    : 1.0
// ============================================================================
module bht
    import branch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_cnt_t         rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int ENTRIES = 2 ** IDX_W;

    bht_cnt_t cnt_arr [ENTRIES];

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_entry
            bht_cnt_t cnt_q;
            bht_cnt_t cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                    if (wr_taken_i) begin
                        if (cnt_q != 2'b11) cnt_d = cnt_q + 2'b01;
                    end else begin
                        if (cnt_q != 2'b00) cnt_d = cnt_q - 2'b01;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) cnt_q <= BHT_RESET;
                else         cnt_q <= cnt_d;
            end

            assign cnt_arr[i] = cnt_q;
        end
    endgenerate

    // Lookup sees the pre-update value when it collides with a write
    assign rd_cnt_o = cnt_arr[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl
// Description : Branch outcome decode, BHT prediction/update, mispredict
//               redirect and flush sequencing, and branch statistics.
// Revision    : 1.0
// ============================================================================
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int IDX_W        = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    output logic             BrUn_o,
    input  logic             BrEq_i,
    input  logic             BrLt_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] misp_cnt_o
);

    localparam int         FC_W       = 4;
    localparam [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    br_state_e        state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

    logic     taken;
    logic     legal;
    logic     resolve;
    logic     mispredict;
    bht_cnt_t pred_cnt;
    logic     unused_bits;

    bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_idx_i   (if_pc_i[IDX_W+1:2]),
        .rd_cnt_o   (pred_cnt),
        .wr_en_i    (resolve),
        .wr_idx_i   (ex_pc_i[IDX_W+1:2]),
        .wr_taken_i (taken)
    );

    assign unused_bits = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0], pred_cnt[0]};

    always_comb begin
        taken      = f3_taken(ex_funct3_i, BrEq_i, BrLt_i);
        legal      = f3_legal(ex_funct3_i);
        // Wrong-path instructions in EX during a flush must not resolve
        resolve    = ex_valid_i & ex_is_branch_i & legal & (state_q == IDLE);
        mispredict = resolve & (taken != ex_pred_taken_i);

        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        misp_cnt_d    = misp_cnt_q;

        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) state_d = IDLE;
                else              fcnt_d  = fcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (resolve) br_cnt_d = br_cnt_q + 1'b1;

        if (mispredict) begin
            redirect_d    = 1'b1;
            redirect_pc_d = taken ? ex_target_i : (ex_pc_i + 32'd4);
            misp_cnt_d    = misp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            fcnt_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            misp_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            misp_cnt_q    <= misp_cnt_d;
        end
    end

    assign if_pred_taken_o = pred_cnt[1];
    assign BrUn_o          = ex_funct3_i[1];
    assign redirect_o      = redirect_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign flush_o         = (state_q == FLUSH);
    assign br_cnt_o        = br_cnt_q;
    assign misp_cnt_o      = misp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Self-checking bench for branch_ctrl: decode table, directed
//               corner sequences and randomized traffic against a model.
// Revision    : 1.0
// ============================================================================
module tb_branch_ctrl;

    localparam int FC = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic        if_pred_taken_o;
    logic        ex_valid_i = 1'b0;
    logic        ex_is_branch_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [31:0] ex_pc_i = '0;
    logic [31:0] ex_target_i = '0;
    logic        ex_pred_taken_i = 1'b0;
    logic        BrUn_o;
    logic        BrEq_i = 1'b0;
    logic        BrLt_i = 1'b0;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] br_cnt_o;
    logic [31:0] misp_cnt_o;

    branch_ctrl #(.IDX_W(6), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (if_pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_is_branch_i  (ex_is_branch_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_pc_i         (ex_pc_i),
        .ex_target_i     (ex_target_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .BrUn_o          (BrUn_o),
        .BrEq_i          (BrEq_i),
        .BrLt_i          (BrLt_i),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .br_cnt_o        (br_cnt_o),
        .misp_cnt_o      (misp_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_bht [64];
    int unsigned m_br, m_misp;
    bit          m_redir;
    bit [31:0]   m_rpc;
    int          m_flush_left;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 64; k++) m_bht[k] = 1;
        m_br = 0; m_misp = 0; m_redir = 0; m_rpc = 0; m_flush_left = 0;
    endtask

    // Returns {legal, taken} from the branch rules
    function automatic logic [1:0] outcome(input logic [2:0] f3, input logic eq, input logic lt);
        if (f3 == 3'd2 || f3 == 3'd3) return 2'b00;
        if (f3 == 3'd0) return {1'b1, eq};
        if (f3 == 3'd1) return {1'b1, !eq};
        if (f3 == 3'd4 || f3 == 3'd6) return {1'b1, lt};
        return {1'b1, !lt};
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic check_regs();
        chk("redirect", {31'd0, redirect_o}, {31'd0, m_redir});
        chk("redirect_pc", redirect_pc_o, m_rpc);
        chk("flush", {31'd0, flush_o}, {31'd0, m_flush_left > 0});
        chk("br_cnt", br_cnt_o, m_br);
        chk("misp_cnt", misp_cnt_o, m_misp);
    endtask

    task automatic step(input logic v, input logic b, input logic [2:0] f3, input logic eq,
                        input logic lt, input logic pred, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] ifpc);
        logic [1:0] oc;
        bit res, misp;
        @(negedge clk_i);
        ex_valid_i = v; ex_is_branch_i = b; ex_funct3_i = f3; BrEq_i = eq; BrLt_i = lt;
        ex_pred_taken_i = pred; ex_pc_i = pc; ex_target_i = tgt; if_pc_i = ifpc;
        #1;
        chk("if_pred", {31'd0, if_pred_taken_o}, {31'd0, m_bht[idx(ifpc)] >= 2});
        chk("BrUn", {31'd0, BrUn_o}, {31'd0, f3 == 3'd6 || f3 == 3'd7 || f3 == 3'd2 || f3 == 3'd3});
        oc   = outcome(f3, eq, lt);
        res  = v && b && oc[1] && (m_flush_left == 0);
        misp = res && (oc[0] != pred);
        @(posedge clk_i);
        #1;
        if (m_flush_left > 0) m_flush_left--;
        else if (misp)        m_flush_left = FC;
        m_redir = misp;
        if (misp) begin
            m_rpc = oc[0] ? tgt : pc + 32'd4;
            m_misp++;
        end
        if (res) begin
            m_br++;
            if (oc[0]) m_bht[idx(pc)] = (m_bht[idx(pc)] == 3) ? 3 : m_bht[idx(pc)] + 1;
            else       m_bht[idx(pc)] = (m_bht[idx(pc)] == 0) ? 0 : m_bht[idx(pc)] - 1;
        end
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 3'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic peek(input logic [31:0] pc, input logic exp, input string nm);
        if_pc_i = pc;
        #1;
        chk(nm, {31'd0, if_pred_taken_o}, {31'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        ex_valid_i = 0;
        rst_ni = 0;
        #1;
        model_reset();
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    typedef struct {
        logic [2:0] f3;
        logic       eq;
        logic       lt;
        logic       exp_taken;
        logic       exp_legal;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int unsigned tbl_br;
        tbl[0]  = '{3'd0, 1, 0, 1, 1};
        tbl[1]  = '{3'd0, 0, 1, 0, 1};
        tbl[2]  = '{3'd1, 0, 0, 1, 1};
        tbl[3]  = '{3'd1, 1, 0, 0, 1};
        tbl[4]  = '{3'd4, 0, 1, 1, 1};
        tbl[5]  = '{3'd4, 1, 0, 0, 1};
        tbl[6]  = '{3'd5, 0, 0, 1, 1};
        tbl[7]  = '{3'd5, 0, 1, 0, 1};
        tbl[8]  = '{3'd6, 0, 1, 1, 1};
        tbl[9]  = '{3'd7, 0, 1, 0, 1};
        tbl[10] = '{3'd2, 1, 1, 0, 0};
        tbl[11] = '{3'd3, 0, 0, 0, 0};

        model_reset();
        do_reset();

        // Reset state
        peek(32'h40, 1'b0, "t1_pred");
        chk("t1_redirect", {31'd0, redirect_o}, 32'd0);
        chk("t1_rpc", redirect_pc_o, 32'd0);
        chk("t1_flush", {31'd0, flush_o}, 32'd0);
        chk("t1_br", br_cnt_o, 32'd0);
        chk("t1_misp", misp_cnt_o, 32'd0);

        // BEQ taken, predicted not-taken
        step(1, 1, 3'd0, 1, 0, 0, 32'h100, 32'h180, 32'h0);
        chk("t2_redirect", {31'd0, redirect_o}, 32'd1);
        chk("t2_rpc", redirect_pc_o, 32'h180);
        chk("t2_flush0", {31'd0, flush_o}, 32'd1);
        chk("t2_misp", misp_cnt_o, 32'd1);
        idle(1);
        chk("t2_flush1", {31'd0, flush_o}, 32'd1);
        chk("t2_redirect1", {31'd0, redirect_o}, 32'd0);
        idle(1);
        chk("t2_flush2", {31'd0, flush_o}, 32'd0);
        peek(32'h100, 1'b1, "t2_bht");

        // BrUn and a correctly predicted BGE
        @(negedge clk_i);
        ex_valid_i = 0; ex_funct3_i = 3'b110;
        #1;
        chk("t3_brun", {31'd0, BrUn_o}, 32'd1);
        step(1, 1, 3'd5, 0, 1, 0, 32'h120, 32'h500, 32'h0);
        chk("t3_redirect", {31'd0, redirect_o}, 32'd0);
        chk("t3_flush", {31'd0, flush_o}, 32'd0);
        chk("t3_br", br_cnt_o, 32'd2);

        // Saturation at 0x200
        do_reset();
        step(1, 1, 3'd0, 1, 0, 0, 32'h200, 32'h300, 32'h0);
        idle(2);
        peek(32'h200, 1'b1, "t4_c10");
        step(1, 1, 3'd0, 1, 0, 1, 32'h200, 32'h300, 32'h0);
        step(1, 1, 3'd0, 1, 0, 1, 32'h200, 32'h300, 32'h0);
        chk("t4_nored", {31'd0, redirect_o}, 32'd0);
        step(1, 1, 3'd0, 0, 0, 1, 32'h200, 32'h300, 32'h0);
        chk("t4_rpc", redirect_pc_o, 32'h204);
        chk("t4_redirect", {31'd0, redirect_o}, 32'd1);
        idle(2);
        peek(32'h200, 1'b1, "t4_c10b");
        step(1, 1, 3'd0, 0, 0, 1, 32'h200, 32'h300, 32'h0);
        idle(2);
        peek(32'h200, 1'b0, "t4_c01");

        // Mispredict in EX during the flush is ignored
        do_reset();
        step(1, 1, 3'd0, 1, 0, 0, 32'h10, 32'h80, 32'h0);
        step(1, 1, 3'd1, 0, 0, 0, 32'h20, 32'h90, 32'h0);
        chk("t5_single", {31'd0, redirect_o}, 32'd0);
        chk("t5_misp", misp_cnt_o, 32'd1);
        chk("t5_br", br_cnt_o, 32'd1);
        chk("t5_rpc", redirect_pc_o, 32'h80);
        idle(2);

        // Illegal funct3, then reset in the middle of a flush
        step(1, 1, 3'd2, 1, 1, 0, 32'h30, 32'h70, 32'h0);
        chk("t6_redirect", {31'd0, redirect_o}, 32'd0);
        chk("t6_br", br_cnt_o, 32'd1);
        step(1, 1, 3'd0, 1, 0, 0, 32'h40, 32'h60, 32'h0);
        step(1, 1, 3'd4, 0, 1, 0, 32'h44, 32'h64, 32'h0);
        do_reset();
        for (int k = 0; k < 64; k++) peek(32'(k * 4), 1'b0, "t6_bht_init");

        // Decode table
        tbl_br = m_br;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, tbl[i].f3, tbl[i].eq, tbl[i].lt, 0, 32'h400 + 32'(i * 4), 32'h800 + 32'(i * 16), 32'h0);
            if (tbl[i].exp_legal) tbl_br++;
            chk("tbl_redirect", {31'd0, redirect_o}, {31'd0, tbl[i].exp_taken});
            chk("tbl_br", br_cnt_o, tbl_br);
            idle(2);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, ifpc;
            pc   = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            ifpc = ($urandom_range(0, 3) == 0) ? pc : 32'h1000 + 32'($urandom_range(0, 63) * 4);
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 1'($urandom), pc, $urandom, ifpc);
        end
        pc_wrap_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Fall-through redirect at the top of the address space wraps to 0
    task automatic pc_wrap_check();
        idle(2);
        step(1, 1, 3'd0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0);
        chk("wrap_rpc", redirect_pc_o, 32'h0);
        idle(2);
    endtask

endmodule
`default_nettype wire
